// File: rtl/mdu_pkg.sv
// Shared op encodings and op-class helpers for the multiply/divide unit.
package mdu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: produces the HI/LO values for the latched op
// plus a divide-by-zero flag so the sequencer can leave HI/LO untouched.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo,
    output logic             div0
);

    logic [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0] uprod;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;

    // One unsigned divider serves both DIV (on magnitudes) and DIVU; the
    // magnitude of the most-negative value is exact as an unsigned number,
    // which makes MIN / -1 come out as MIN with a zero remainder.
    always_comb begin
        sprod    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        uprod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        sign_a   = a[WIDTH-1];
        sign_b   = b[WIDTH-1];
        div0     = is_div(op) && (b == '0);
        dividend = a;
        divisor  = b;
        if (op == OP_DIV) begin
            dividend = sign_a ? -a : a;
            divisor  = sign_b ? -b : b;
        end
        if (divisor == '0) begin
            divisor = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        uq = dividend / divisor;
        ur = dividend % divisor;

        next_hi = '0;
        next_lo = '0;
        case (op)
            OP_MULT:  {next_hi, next_lo} = sprod;
            OP_MULTU: {next_hi, next_lo} = uprod;
            OP_DIV: begin
                next_lo = (sign_a ^ sign_b) ? -uq : uq;
                next_hi = sign_a ? -ur : ur;
            end
            OP_DIVU: begin
                next_lo = uq;
                next_hi = ur;
            end
            default: begin
                next_hi = '0;
                next_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy stalls the pipe.
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight op.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;
    logic             div0;
    logic             cancel_hit;

`ifdef MDU_CANCEL_EN
    assign cancel_hit = cancel;
`else
    assign cancel_hit = 1'b0;
`endif

    assign busy = (state == ST_BUSY);

    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .next_hi (next_hi),
        .next_lo (next_lo),
        .div0    (div0)
    );

    // Arithmetic ops latch operands and count down; moves write HI/LO at once.
    // Any start seen while busy is dropped, the hazard unit stalls it instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_NOP;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == ST_IDLE) begin
            if (start && !cancel_hit) begin
                if (is_mul(op) || is_div(op)) begin
                    op_q  <= op;
                    a_q   <= a;
                    b_q   <= b;
                    cnt   <= is_mul(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state <= ST_BUSY;
                end else if (op == OP_MTHI) begin
                    hi <= a;
                end else if (op == OP_MTLO) begin
                    lo <= a;
                end
            end
        end else begin
            if (cancel_hit) begin
                cnt   <= '0;
                state <= ST_IDLE;
            end else if (cnt == CNT_W'(1)) begin
                if (!div0) begin
                    hi <= next_hi;
                    lo <= next_lo;
                end
                cnt   <= '0;
                state <= ST_IDLE;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed + randomized scoreboard bench for mdu_seq: busy length, HI/LO results,
// move ops, ignored starts while busy, reset mid-operation and optional cancel.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int MC    = 5;
    localparam int DC    = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [OP_W-1:0]   op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
`ifdef MDU_CANCEL_EN
    logic              cancel;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mdu_seq #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC),
        .CNT_W       (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [OP_W-1:0] o, input logic [31:0] aa,
                                 input logic [31:0] bb, input logic [31:0] eh,
                                 input logic [31:0] el, input int cyc, input string tag);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NOP;
        e.hi = eh; e.lo = el; e.cycles = cyc; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic applyMove(input logic [OP_W-1:0] o, input logic [31:0] val);
        @(negedge clk);
        start = 1'b1; op = o; a = val;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NOP;
    endtask

    task automatic checkOutput();
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL sb_empty: observed=0 entries expected=1");
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk({e.tag, "_cycles"}, 32'(n), 32'(e.cycles));
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
    endtask

    logic [31:0] ra;
    logic [31:0] rb;
    longint      sp;
    logic [63:0] up;
    int          si;
    int          sd;

    initial begin
        reset = 1'b1; start = 1'b0; op = OP_NOP; a = '0; b = '0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC, "mult_neg");
        checkOutput();
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MC, "multu");
        checkOutput();
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div_neg");
        checkOutput();
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DC, "div_ovf");
        checkOutput();

        applyMove(OP_MTHI, 32'h11);
        chk("preset_hi", hi, 32'h11);
        applyMove(OP_MTLO, 32'h22);
        chk("preset_lo", lo, 32'h22);
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, DC, "divu_by0");
        checkOutput();

        // MTHI immediately followed by MULT, then an MTLO dropped while busy
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h1234;
        @(posedge clk); #1;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        op = OP_MULT; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        chk("mult_b2b_busy", {31'b0, busy}, 32'd1);
        op = OP_MTLO; a = 32'h55;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NOP;
        chk("mtlo_ignored_lo", lo, 32'h22);
        chk("busy_hi_held", hi, 32'h1234);
        begin
            exp_t e;
            e.hi = 32'h0; e.lo = 32'h6; e.cycles = MC - 1; e.tag = "mult_b2b";
            sb.push_back(e);
        end
        checkOutput();

        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            sp = longint'(int'(ra)) * longint'(int'(rb));
            applyStimulus(OP_MULT, ra, rb, sp[63:32], sp[31:0], MC, "rand_mult");
            checkOutput();
            up = 64'(ra) * 64'(rb);
            applyStimulus(OP_MULTU, ra, rb, up[63:32], up[31:0], MC, "rand_multu");
            checkOutput();
            rb = rb | 32'h1;
            applyStimulus(OP_DIVU, ra, rb, ra % rb, ra / rb, DC, "rand_divu");
            checkOutput();
            si = int'(ra); sd = int'({rb[31], 15'b0, rb[15:0]}) | 1;
            applyStimulus(OP_DIV, ra, 32'(sd), 32'(si % sd), 32'(si / sd), DC, "rand_div");
            checkOutput();
        end

        // Reset in the third busy cycle aborts and clears HI/LO
        applyMove(OP_MTHI, 32'hABCD);
        applyMove(OP_MTLO, 32'h4321);
        applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, DC, "div_reset");
        void'(sb.pop_back());
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);

`ifdef MDU_CANCEL_EN
        applyMove(OP_MTHI, 32'h77);
        applyMove(OP_MTLO, 32'h88);
        applyStimulus(OP_MULT, 32'd5, 32'd5, 32'd0, 32'd25, MC, "cancel");
        void'(sb.pop_back());
        @(posedge clk); #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy", {31'b0, busy}, 32'd0);
        chk("cancel_hi", hi, 32'h77);
        chk("cancel_lo", lo, 32'h88);
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NOP; cancel = 1'b0;
        chk("cancel_start_busy", {31'b0, busy}, 32'd0);
        repeat (MC + 1) @(posedge clk);
        #1 chk("cancel_start_lo", lo, 32'h88);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
